snn_spike_decoder: RTL and testbench

//  Output-side rate decoder for snn_top: counts spikes per output neuron over a fixed

---
 rtl/snn_pkg.sv | 21 ++
 rtl/snn_argmax.sv | 30 +++
 rtl/snn_spike_decoder.sv | 125 ++++++++++++
 tb/tb_snn_spike_decoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared defaults, state encodings and helpers for the SNN spike decoder.
package snn_pkg;

  localparam int SNN_N_CH  = 3;
  localparam int SNN_CNT_W = 8;

  typedef logic [SNN_CNT_W-1:0] cnt_t;

  // FSM encodings kept as plain constants so older tools and netlists see fixed codes
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  // Width of a channel index; a single channel still needs one bit to be a legal port
  function automatic int cls_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SNN_CLS_W = cls_w(SNN_N_CH);

endpackage

// File: rtl/snn_argmax.sv
// Combinational argmax over N_CH counters; ties go to the lowest index.
module snn_argmax
  import snn_pkg::*;
#(
  parameter  int N_CH  = SNN_N_CH,
  parameter  int CNT_W = SNN_CNT_W,
  localparam int CLS_W = cls_w(N_CH)
) (
  input  logic [N_CH-1:0][CNT_W-1:0] i_cnt,
  output logic [CLS_W-1:0]           o_idx,
  output logic                       o_all_zero
);

  logic [CNT_W-1:0] best;

  // Linear scan; strict '>' keeps the earlier channel on a tie
  always_comb begin
    best  = i_cnt[0];
    o_idx = '0;
    for (int k = 1; k < N_CH; k++) begin
      if (i_cnt[k] > best) begin
        best  = i_cnt[k];
        o_idx = CLS_W'(k);
      end
    end
    // The maximum is zero only when every channel is zero
    o_all_zero = (best == '0);
  end

endmodule

// File: rtl/snn_spike_decoder.sv
// Rate decoder: counts spikes per channel over a fixed window, then reports
// counts and the winning class with a one-cycle valid strobe.
module snn_spike_decoder
  import snn_pkg::*;
#(
  parameter  int N_CH   = SNN_N_CH,
  parameter  int WINDOW = 64,
  parameter  int CNT_W  = SNN_CNT_W,
  localparam int CLS_W  = cls_w(N_CH)
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [N_CH-1:0]       i_spike,
  input  logic                  i_start,
  input  logic                  i_continuous,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [N_CH*CNT_W-1:0] o_counts,
  output logic [CLS_W-1:0]      o_class,
  output logic                  o_none
);

  localparam int WIN_W = $clog2(WINDOW);

  logic [1:0]                  state_q, state_d;
  logic [WIN_W-1:0]            win_q, win_d;
  logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [N_CH-1:0][CNT_W-1:0]  counts_q, counts_d;
  logic [CLS_W-1:0]            class_q, class_d;
  logic                        none_q, none_d;
  logic                        valid_q, valid_d;
  logic                        busy_q, busy_d;
  logic [CLS_W-1:0]            am_idx;
  logic                        am_zero;
  logic                        win_last;

  // Saturating per-channel increment including this cycle's spikes
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      cnt_inc[k] = (i_spike[k] && (cnt_q[k] != {CNT_W{1'b1}})) ? cnt_q[k] + 1'b1 : cnt_q[k];
    end
  end

  // Argmax sees the final counts so the last ACCUM cycle's spikes are included
  snn_argmax #(.N_CH(N_CH), .CNT_W(CNT_W)) u_argmax (
    .i_cnt      (cnt_inc),
    .o_idx      (am_idx),
    .o_all_zero (am_zero)
  );

  assign win_last = (win_q == WIN_W'(WINDOW - 1));

  // FSM, window counter and report capture
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    counts_d = counts_q;
    class_d  = class_q;
    none_d   = none_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_ACCUM;
          win_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_ACCUM: begin
        if (win_last) begin
          state_d  = ST_REPORT;
          win_d    = '0;
          cnt_d    = '0;
          counts_d = cnt_inc;
          class_d  = am_idx;
          none_d   = am_zero;
          valid_d  = 1'b1;
        end else begin
          win_d = win_q + 1'b1;
          cnt_d = cnt_inc;
        end
      end
      ST_REPORT: begin
        state_d = i_continuous ? ST_ACCUM : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        win_d   = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset discards any partial window
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      cnt_q    <= '0;
      counts_q <= '0;
      class_q  <= '0;
      none_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      counts_q <= counts_d;
      class_q  <= class_d;
      none_q   <= none_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign o_busy   = busy_q;
  assign o_valid  = valid_q;
  assign o_counts = counts_q;
  assign o_class  = class_q;
  assign o_none   = none_q;

endmodule

// File: tb/tb_snn_spike_decoder.sv
// Directed bench for snn_spike_decoder: an 8-bit instance for the main checks and
// a 4-bit instance sharing the same stimulus for saturation.
module tb_snn_spike_decoder;

  logic        clk = 1'b0;
  logic        i_rstn;
  logic [2:0]  i_spike;
  logic        i_start;
  logic        i_continuous;

  logic        o_busy, o_valid, o_none;
  logic [23:0] o_counts;
  logic [1:0]  o_class;
  logic        s_busy, s_valid, s_none;
  logic [11:0] s_counts;
  logic [1:0]  s_class;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  snn_spike_decoder #(.N_CH(3), .WINDOW(64), .CNT_W(8)) dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_spike(i_spike), .i_start(i_start),
    .i_continuous(i_continuous), .o_busy(o_busy), .o_valid(o_valid),
    .o_counts(o_counts), .o_class(o_class), .o_none(o_none)
  );

  snn_spike_decoder #(.N_CH(3), .WINDOW(64), .CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rstn(i_rstn), .i_spike(i_spike), .i_start(i_start),
    .i_continuous(i_continuous), .o_busy(s_busy), .o_valid(s_valid),
    .o_counts(s_counts), .o_class(s_class), .o_none(s_none)
  );

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse i_start (sampled at the next rising edge, spikes there are ignored)
  task automatic start_pulse();
    i_start = 1'b1;
    i_spike = 3'b000;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_spike = '0; i_start = 1'b0; i_continuous = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({o_busy, o_valid, o_counts, o_class, o_none} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b valid=%b counts=%h class=%0d none=%b, want all 0",
               o_busy, o_valid, o_counts, o_class, o_none);
    end
    i_rstn = 1'b1;
    begin
      bit seen = 1'b0;
      for (int j = 0; j < 10; j++) begin
        i_spike = 3'b111;
        tick();
        if (o_busy || o_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle: busy/valid seen=%b without i_start, want 0", seen);
      end
    end
    i_spike = '0;
  endtask

  task automatic test_single_window();
    bit early = 1'b0;
    start_pulse();
    for (int j = 0; j < 64; j++) begin
      i_spike = {(j % 4 == 0), (j % 2 == 0), 1'b1};
      if (o_valid) early = 1'b1;
      tick();
    end
    i_spike = '0;
    // o_valid high after the 64th ACCUM edge, seen by the 65th edge after start
    n_cmp++;
    if (early !== 1'b0 || o_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_latency: early=%b valid=%b, want early=0 valid=1", early, o_valid);
    end
    n_cmp++;
    if (o_counts !== {8'd16, 8'd32, 8'd64} || o_class !== 2'd0 || o_none !== 1'b0) begin
      n_bad++;
      $display("FAIL single_result: counts=%h class=%0d none=%b, want 102040 class=0 none=0",
               o_counts, o_class, o_none);
    end
    tick();
    n_cmp++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_counts !== {8'd16, 8'd32, 8'd64}) begin
      n_bad++;
      $display("FAIL single_after: busy=%b valid=%b counts=%h, want busy=0 valid=0 counts held",
               o_busy, o_valid, o_counts);
    end
  endtask

  task automatic test_saturation();
    start_pulse();
    for (int j = 0; j < 64; j++) begin
      i_spike = {1'b1, (j < 5), (j < 5)};
      tick();
    end
    i_spike = '0;
    n_cmp++;
    if (s_valid !== 1'b1 || s_counts !== {4'd15, 4'd5, 4'd5} || s_class !== 2'd2 || s_none !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_clamp: valid=%b counts=%h class=%0d none=%b, want valid=1 counts=f55 class=2 none=0",
               s_valid, s_counts, s_class, s_none);
    end
    n_cmp++;
    if (o_counts !== {8'd64, 8'd5, 8'd5} || o_class !== 2'd2) begin
      n_bad++;
      $display("FAIL sat_wide: counts=%h class=%0d, want 400505 class=2", o_counts, o_class);
    end
    tick();
    start_pulse();
    for (int j = 0; j < 64; j++) begin
      i_spike = {1'b0, (j < 5), (j < 5)};
      tick();
    end
    i_spike = '0;
    n_cmp++;
    if (s_valid !== 1'b1 || s_counts !== {4'd0, 4'd5, 4'd5} || s_class !== 2'd0) begin
      n_bad++;
      $display("FAIL sat_tie: valid=%b counts=%h class=%0d, want valid=1 counts=055 class=0",
               s_valid, s_counts, s_class);
    end
    tick();
  endtask

  task automatic test_boundaries();
    // Spikes while idle must not leak into the window
    i_spike = 3'b111;
    repeat (3) tick();
    start_pulse();
    for (int j = 0; j < 64; j++) begin
      i_spike = (j == 63) ? 3'b010 : 3'b000;
      tick();
    end
    n_cmp++;
    if (o_valid !== 1'b1 || o_counts !== {8'd0, 8'd1, 8'd0} || o_class !== 2'd1 || o_none !== 1'b0) begin
      n_bad++;
      $display("FAIL bound_last: valid=%b counts=%h class=%0d none=%b, want valid=1 counts=000100 class=1 none=0",
               o_valid, o_counts, o_class, o_none);
    end
    // Spikes in the REPORT cycle and afterwards in IDLE
    i_spike = 3'b111;
    repeat (4) tick();
    start_pulse();
    for (int j = 0; j < 64; j++) begin
      i_spike = 3'b000;
      tick();
    end
    n_cmp++;
    if (o_valid !== 1'b1 || o_counts !== 24'd0 || o_class !== 2'd0 || o_none !== 1'b1) begin
      n_bad++;
      $display("FAIL bound_none: valid=%b counts=%h class=%0d none=%b, want valid=1 counts=0 class=0 none=1",
               o_valid, o_counts, o_class, o_none);
    end
    tick();
  endtask

  task automatic test_continuous();
    bit stray;
    int pulses = 0;
    i_continuous = 1'b1;
    start_pulse();
    for (int w = 0; w < 3; w++) begin
      stray = 1'b0;
      for (int j = 0; j < 64; j++) begin
        i_spike = {1'b0, (j % 8 == 0), 1'b0};
        i_start = (w == 1 && j == 20);
        if (o_valid) stray = 1'b1;
        tick();
      end
      i_start = 1'b0;
      i_spike = '0;
      if (o_valid) pulses++;
      n_cmp++;
      if (stray !== 1'b0 || o_valid !== 1'b1 || o_counts !== {8'd0, 8'd8, 8'd0} || o_class !== 2'd1) begin
        n_bad++;
        $display("FAIL cont_win%0d: stray=%b valid=%b counts=%h class=%0d, want stray=0 valid=1 counts=000800 class=1",
                 w, stray, o_valid, o_counts, o_class);
      end
      if (w == 2) i_continuous = 1'b0;
      tick();
    end
    stray = 1'b0;
    for (int j = 0; j < 70; j++) begin
      if (o_busy || o_valid) stray = 1'b1;
      tick();
    end
    n_cmp++;
    if (pulses !== 3 || stray !== 1'b0) begin
      n_bad++;
      $display("FAIL cont_stop: pulses=%0d busy/valid after stop=%b, want 3 and 0", pulses, stray);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    start_pulse();
    for (int j = 0; j < 30; j++) begin
      i_spike = 3'b111;
      tick();
    end
    i_rstn = 1'b0;
    tick();
    n_cmp++;
    if ({o_busy, o_valid, o_counts, o_class, o_none} !== 29'd0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: busy=%b valid=%b counts=%h class=%0d none=%b, want all 0",
               o_busy, o_valid, o_counts, o_class, o_none);
    end
    i_rstn = 1'b1;
    i_spike = '0;
    for (int j = 0; j < 80; j++) begin
      if (o_valid || o_busy) seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_novalid: busy/valid seen=%b after reset, want 0", seen);
    end
    start_pulse();
    for (int j = 0; j < 64; j++) begin
      i_spike = {1'b1, 1'b0, (j < 3)};
      tick();
    end
    i_spike = '0;
    n_cmp++;
    if (o_valid !== 1'b1 || o_counts !== {8'd64, 8'd0, 8'd3} || o_class !== 2'd2 || o_none !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_fresh: valid=%b counts=%h class=%0d none=%b, want valid=1 counts=400003 class=2 none=0",
               o_valid, o_counts, o_class, o_none);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_saturation();
    test_boundaries();
    test_continuous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
